// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the fetch PC generator, the decoder and CP0.
//   - npc_op encodings (values 5-7 behave as sequential fetch)
//   - PC generator FSM state encoding
//   - default reset / kernel entry / instruction-memory window addresses
//   - is_redirect(): true for any npc_op that replaces the sequential PC
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_J    = 3'd1,
        NPC_JR   = 3'd2,
        NPC_B    = 3'd3,
        NPC_ERET = 3'd4
    } npc_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_KERNEL_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_LIMIT  = 32'h0000_6FFF;

    function automatic logic is_redirect(input logic [2:0] op);
        case (op)
            NPC_J, NPC_JR, NPC_B, NPC_ERET: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_gen_npc_target.sv
// npc_target: purely combinational redirect-target computation.
//   i_npc_op  [2:0]  D-stage next-PC selection
//   i_d_pc    [31:0] D-stage instruction PC
//   i_imm26   [25:0] D-stage immediate field
//   i_jreg    [31:0] forwarded register jump target
//   i_epc     [31:0] CP0 return address
//   o_target  [31:0] computed redirect target
//   o_redirect       1 when i_npc_op selects a non-sequential target
module npc_target
    import pc_gen_pkg::*;
(
    input  logic [2:0]  i_npc_op,
    input  logic [31:0] i_d_pc,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_jreg,
    input  logic [31:0] i_epc,
    output logic [31:0] o_target,
    output logic        o_redirect
);

    logic [31:0] w_pc4;
    logic [31:0] w_b_off;

    assign w_pc4   = i_d_pc + 32'd4;
    // Branch offset: sign-extended 16-bit word offset converted to bytes.
    assign w_b_off = {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};

    // Select the redirect target for the current D-stage decision.
    always_comb begin
        o_target   = w_pc4;
        o_redirect = is_redirect(i_npc_op);
        case (i_npc_op)
            NPC_J:    o_target = {w_pc4[31:28], i_imm26, 2'b00};
            NPC_JR:   o_target = i_jreg;
            NPC_B:    o_target = w_pc4 + w_b_off;
            NPC_ERET: o_target = i_epc;
            default:  o_target = w_pc4;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with deferred redirect during stalls.
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall                 hold the F-stage PC
//   npc_op [2:0]          D-stage next-PC decision (SEQ/J/JR/B/ERET)
//   d_pc, imm26           D-stage PC and immediate for J/B targets
//   jreg, epc             JR and ERET targets
//   int_exc_req           CP0 request: jump to KERNEL_PC unconditionally
//   f_pc [31:0]           registered fetch PC
//   f_adel                fetch address error (misaligned or outside IM window)
//   redir_pending         registered, high while a redirect is held over a stall
// A redirect decided while stalled is captured once (first wins) and applied
// on the first unstalled sequential cycle; a fresh redirect or an interrupt
// supersedes it.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] KERNEL_PC = DEF_KERNEL_PC,
    parameter logic [31:0] IM_BASE   = DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT  = DEF_IM_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic [31:0] d_pc,
    input  logic [25:0] imm26,
    input  logic [31:0] jreg,
    input  logic [31:0] epc,
    input  logic        int_exc_req,
    output logic [31:0] f_pc,
    output logic        f_adel,
    output logic        redir_pending
);

    logic [31:0] r_pc;
    logic [31:0] r_pend_target;
    pc_state_e   r_state;
    logic        r_redir_pending;
    logic [31:0] w_target;
    logic        w_redirect;

    npc_target u_npc_target (
        .i_npc_op   (npc_op),
        .i_d_pc     (d_pc),
        .i_imm26    (imm26),
        .i_jreg     (jreg),
        .i_epc      (epc),
        .o_target   (w_target),
        .o_redirect (w_redirect)
    );

    // PC register, pending-target register and IDLE/HELD state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_pend_target   <= 32'h0000_0000;
            r_state         <= ST_IDLE;
            r_redir_pending <= 1'b0;
        end else if (int_exc_req) begin
            r_pc            <= KERNEL_PC;
            r_pend_target   <= 32'h0000_0000;
            r_state         <= ST_IDLE;
            r_redir_pending <= 1'b0;
        end else if (!stall) begin
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (r_state == ST_HELD) begin
                r_pc <= r_pend_target;
            end else begin
                r_pc <= r_pc + 32'd4;
            end
            r_pend_target   <= 32'h0000_0000;
            r_state         <= ST_IDLE;
            r_redir_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_redirect) begin
                        r_pend_target   <= w_target;
                        r_state         <= ST_HELD;
                        r_redir_pending <= 1'b1;
                    end else begin
                        r_state         <= ST_IDLE;
                        r_redir_pending <= 1'b0;
                    end
                end
                ST_HELD: begin
                    // First captured target is kept; later ones are dropped.
                    r_state         <= ST_HELD;
                    r_redir_pending <= 1'b1;
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_redir_pending <= 1'b0;
                end
            endcase
        end
    end

    assign f_pc          = r_pc;
    assign redir_pending = r_redir_pending;
    assign f_adel        = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_op;
    logic [31:0] d_pc;
    logic [25:0] imm26;
    logic [31:0] jreg;
    logic [31:0] epc;
    logic        int_exc_req;
    logic [31:0] f_pc;
    logic        f_adel;
    logic        redir_pending;

    int n_vec;
    int n_bad;

    pc_gen dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .npc_op        (npc_op),
        .d_pc          (d_pc),
        .imm26         (imm26),
        .jreg          (jreg),
        .epc           (epc),
        .int_exc_req   (int_exc_req),
        .f_pc          (f_pc),
        .f_adel        (f_adel),
        .redir_pending (redir_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [2:0]  op;
        logic [31:0] d_pc;
        logic [25:0] imm;
        logic [31:0] jreg;
        logic [31:0] epc;
        logic        irq;
        logic [31:0] e_pc;
        logic        e_pend;
        logic        e_adel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic [2:0] op, logic [31:0] dp, logic [25:0] im,
                                logic [31:0] jr, logic [31:0] ep, logic irq,
                                logic [31:0] epc_exp, logic pend, logic adel);
        vec_t v;
        v.stall = s; v.op = op; v.d_pc = dp; v.imm = im; v.jreg = jr; v.epc = ep;
        v.irq = irq; v.e_pc = epc_exp; v.e_pend = pend; v.e_adel = adel;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic s, logic [2:0] op, logic [31:0] dp, logic [25:0] im,
                         logic [31:0] jr, logic [31:0] ep, logic irq);
        stall = s; npc_op = op; d_pc = dp; imm26 = im; jreg = jr; epc = ep; int_exc_req = irq;
    endtask

    // Reference model state: fetch PC and at most one deferred target.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    function automatic logic [31:0] m_target(int op, logic [31:0] dp, logic [25:0] im,
                                             logic [31:0] jr, logic [31:0] ep);
        logic [31:0] seq;
        int off;
        seq = dp + 32'd4;
        off = int'($signed(im[15:0]));
        case (op)
            1:       return (seq & 32'hF000_0000) | ({6'd0, im} << 2);
            2:       return jr;
            3:       return seq + 32'(off * 4);
            4:       return ep;
            default: return seq;
        endcase
    endfunction

    function automatic logic m_adel(logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFF);
    endfunction

    task automatic m_step(logic s, int op, logic [31:0] dp, logic [25:0] im,
                          logic [31:0] jr, logic [31:0] ep, logic irq);
        logic redirect;
        redirect = (op >= 1) && (op <= 4);
        if (irq) begin
            m_pc = 32'h0000_4180;
            m_q.delete();
        end else if (!s) begin
            if (redirect) m_pc = m_target(op, dp, im, jr, ep);
            else if (m_q.size() > 0) m_pc = m_q[0];
            else m_pc = m_pc + 32'd4;
            m_q.delete();
        end else if (redirect && m_q.size() == 0) begin
            m_q.push_back(m_target(op, dp, im, jr, ep));
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        drive(1'b0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
        #12;
        chk("reset_f_pc", f_pc, 32'h0000_3000);
        chk("reset_adel", {31'd0, f_adel}, 32'd0);
        chk("reset_pend", {31'd0, redir_pending}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_f_pc", f_pc, 32'h0000_3000);

        tbl.push_back(mk(0, 3'd0, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_3004, 0, 0));
        tbl.push_back(mk(0, 3'd0, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_3008, 0, 0));
        tbl.push_back(mk(0, 3'd0, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_300C, 0, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0000_3010, 26'h000FFFF, 32'h0,         32'h0,         0, 32'h0000_3010, 0, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0000_3010, 26'h0000004, 32'h0,         32'h0,         0, 32'h0000_3024, 0, 0));
        tbl.push_back(mk(1, 3'd2, 32'h0,         26'h0,       32'h0000_3100, 32'h0,         0, 32'h0000_3024, 1, 0));
        tbl.push_back(mk(1, 3'd2, 32'h0,         26'h0,       32'h0000_3200, 32'h0,         0, 32'h0000_3024, 1, 0));
        tbl.push_back(mk(1, 3'd2, 32'h0,         26'h0,       32'h0000_3300, 32'h0,         0, 32'h0000_3024, 1, 0));
        tbl.push_back(mk(0, 3'd0, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_3100, 0, 0));
        tbl.push_back(mk(1, 3'd1, 32'h0000_3100, 26'h0000C80, 32'h0,         32'h0,         0, 32'h0000_3100, 1, 0));
        tbl.push_back(mk(1, 3'd0, 32'h0,         26'h0,       32'h0,         32'h0,         1, 32'h0000_4180, 0, 0));
        tbl.push_back(mk(0, 3'd4, 32'h0,         26'h0,       32'h0,         32'h0000_3002, 0, 32'h0000_3002, 0, 1));
        tbl.push_back(mk(0, 3'd2, 32'h0,         26'h0,       32'h0000_7000, 32'h0,         0, 32'h0000_7000, 0, 1));
        tbl.push_back(mk(0, 3'd1, 32'h0000_3000, 26'h0000C00, 32'h0,         32'h0,         0, 32'h0000_3000, 0, 0));
        tbl.push_back(mk(0, 3'd5, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_3004, 0, 0));
        tbl.push_back(mk(1, 3'd0, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_3004, 0, 0));
        tbl.push_back(mk(1, 3'd2, 32'h0,         26'h0,       32'h0000_3300, 32'h0,         0, 32'h0000_3004, 1, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0000_3010, 26'h0000004, 32'h0,         32'h0,         0, 32'h0000_3024, 0, 0));
        tbl.push_back(mk(0, 3'd7, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_3028, 0, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0,         26'h0,       32'h0000_3500, 32'h0,         1, 32'h0000_4180, 0, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0,         26'h0,       32'hFFFF_FFFC, 32'h0,         0, 32'hFFFF_FFFC, 0, 1));
        tbl.push_back(mk(0, 3'd0, 32'h0,         26'h0,       32'h0,         32'h0,         0, 32'h0000_0000, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].op, tbl[i].d_pc, tbl[i].imm, tbl[i].jreg, tbl[i].epc, tbl[i].irq);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_f_pc", i), f_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_pend", i), {31'd0, redir_pending}, {31'd0, tbl[i].e_pend});
            chk($sformatf("tbl%0d_adel", i), {31'd0, f_adel}, {31'd0, tbl[i].e_adel});
        end

        // Randomized phase, model starts from the last table state.
        m_pc = 32'h0000_0000;
        m_q.delete();
        for (int k = 0; k < 400; k++) begin
            logic s, irq;
            logic [2:0] op;
            logic [31:0] dp, jr, ep;
            logic [25:0] im;
            s   = ($urandom_range(0, 9) < 4);
            irq = ($urandom_range(0, 19) == 0);
            op  = 3'($urandom_range(0, 7));
            dp  = 32'h0000_3000 + {$urandom_range(0, 4095), 2'b00};
            im  = 26'($urandom);
            jr  = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0000_3000 + {$urandom_range(0, 4095), 2'b00});
            ep  = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0000_3000 + {$urandom_range(0, 4095), 2'b00});
            drive(s, op, dp, im, jr, ep, irq);
            m_step(s, int'(op), dp, im, jr, ep, irq);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_f_pc", k), f_pc, m_pc);
            chk($sformatf("rnd%0d_pend", k), {31'd0, redir_pending}, (m_q.size() > 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_adel", k), {31'd0, f_adel}, {31'd0, m_adel(m_pc)});
        end

        // Async reset between edges while a redirect is held.
        drive(0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        drive(1, 3'd2, 32'h0, 26'h0, 32'h0000_3100, 32'h0, 0);
        @(posedge clk);
        #1;
        chk("held_pend", {31'd0, redir_pending}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_f_pc", f_pc, 32'h0000_3000);
        chk("async_pend", {31'd0, redir_pending}, 32'd0);
        chk("async_adel", {31'd0, f_adel}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 0);
        #1;
        chk("post_rst_f_pc", f_pc, 32'h0000_3000);
        @(posedge clk);
        #1;
        chk("post_rst_seq", f_pc, 32'h0000_3004);
        chk("post_rst_pend", {31'd0, redir_pending}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
